// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures instruction memory data into the IF/ID register.
// Define FETCH_PERF_COUNTERS_EN to add fetch/stall/redirect performance counters.
module instruction_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] PC_STEP   = 1,
    parameter logic [XLEN-1:0] HALT_INSN = 32'h00000073
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] ins_addr,
    input  logic [XLEN-1:0] instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            halted
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [XLEN-1:0] perf_fetches,
    output logic [XLEN-1:0] perf_stalls,
    output logic [XLEN-1:0] perf_redirects
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            load;

    assign ins_addr = pc;
    assign load     = (state == RUN) && (!id_valid || id_ready);

    // Redirect outranks capture so a wrong-path instruction (including an ECALL) never survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= BOOT;
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_target;
            id_valid <= 1'b0;
            state    <= RUN;
            halted   <= 1'b0;
        end else if (load) begin
            id_instr <= instruction;
            id_pc    <= pc;
            id_valid <= 1'b1;
            if (instruction == HALT_INSN) begin
                state  <= HALTED;
                halted <= 1'b1;
            end else begin
                pc <= pc + PC_STEP;
            end
        end else begin
            if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end
            if (state == BOOT) begin
                state <= RUN;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    // Fetches count actual captures, so a load cycle overridden by a redirect is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches   <= '0;
            perf_stalls    <= '0;
            perf_redirects <= '0;
        end else begin
            if (load && !redirect_valid) begin
                perf_fetches <= perf_fetches + 1'b1;
            end
            if ((state == RUN) && id_valid && !id_ready) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
            if (redirect_valid) begin
                perf_redirects <= perf_redirects + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit: boot latency, stall, redirect, halt, wrap, async reset.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ins_addr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_stalls;
    logic [31:0] perf_redirects;
`endif

    logic [31:0] imem [0:15];
    int          checkCount = 0;
    int          passCount  = 0;

    always #5 clk = ~clk;

    assign instruction = imem[ins_addr[3:0]];

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ins_addr        (ins_addr),
        .instruction     (instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .halted          (halted)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetches    (perf_fetches),
        .perf_stalls     (perf_stalls),
        .perf_redirects  (perf_redirects)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive inputs for the coming edge, then return at the following falling edge.
    task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] target);
        id_ready        = ready;
        redirect_valid  = rv;
        redirect_target = target;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            imem[i] = 32'h10000000 | i;
        end
        imem[0] = 32'h00300293;
        imem[1] = 32'h00400313;
        imem[2] = 32'h005303b3;
        imem[6] = 32'h00000073;

        rst_n           = 1'b0;
        id_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        #1;
        checkOutput("rst_valid",  {31'b0, id_valid}, 32'h0);
        checkOutput("rst_instr",  id_instr, 32'h0);
        checkOutput("rst_pc",     id_pc, 32'h0);
        checkOutput("rst_addr",   ins_addr, 32'h0);
        checkOutput("rst_halted", {31'b0, halted}, 32'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("boot_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("boot_addr",  ins_addr, 32'h0);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("e2_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("e2_instr", id_instr, 32'h00300293);
        checkOutput("e2_pc",    id_pc, 32'h0);
        checkOutput("e2_addr",  ins_addr, 32'h1);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("e3_instr", id_instr, 32'h00400313);
        checkOutput("e3_pc",    id_pc, 32'h1);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("e4_instr", id_instr, 32'h005303b3);
        checkOutput("e4_pc",    id_pc, 32'h2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("stall_instr", id_instr, 32'h005303b3);
            checkOutput("stall_pc",    id_pc, 32'h2);
            checkOutput("stall_addr",  ins_addr, 32'h3);
            checkOutput("stall_valid", {31'b0, id_valid}, 32'h1);
        end

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("resume_pc",   id_pc, 32'h3);
        checkOutput("resume_addr", ins_addr, 32'h4);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("pre_redir_pc", id_pc, 32'h4);

        applyStimulus(1'b1, 1'b1, 32'h8);
        checkOutput("redir_squash", {31'b0, id_valid}, 32'h0);
        checkOutput("redir_addr",   ins_addr, 32'h8);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("tgt_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("tgt_pc",    id_pc, 32'h8);
        checkOutput("tgt_instr", id_instr, 32'h10000008);

        applyStimulus(1'b1, 1'b1, 32'h5);
        checkOutput("redir5_addr", ins_addr, 32'h5);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("pre_halt_pc",     id_pc, 32'h5);
        checkOutput("pre_halt_halted", {31'b0, halted}, 32'h0);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("halt_flag",  {31'b0, halted}, 32'h1);
        checkOutput("halt_instr", id_instr, 32'h00000073);
        checkOutput("halt_pc",    id_pc, 32'h6);
        checkOutput("halt_addr",  ins_addr, 32'h6);
        checkOutput("halt_valid", {31'b0, id_valid}, 32'h1);

        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("halt_hold_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("halt_hold_addr",  ins_addr, 32'h6);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("halt_drain_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("halt_drain_flag",  {31'b0, halted}, 32'h1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("halted_idle_valid", {31'b0, id_valid}, 32'h0);
            checkOutput("halted_idle_addr",  ins_addr, 32'h6);
        end

        applyStimulus(1'b1, 1'b1, 32'h2);
        checkOutput("unhalt_flag",  {31'b0, halted}, 32'h0);
        checkOutput("unhalt_addr",  ins_addr, 32'h2);
        checkOutput("unhalt_valid", {31'b0, id_valid}, 32'h0);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("unhalt_pc",    id_pc, 32'h2);
        checkOutput("unhalt_instr", id_instr, 32'h005303b3);

        applyStimulus(1'b1, 1'b1, 32'hFFFFFFFF);
        checkOutput("wrap_redir_addr", ins_addr, 32'hFFFFFFFF);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap_pc",    id_pc, 32'hFFFFFFFF);
        checkOutput("wrap_instr", id_instr, 32'h1000000F);
        checkOutput("wrap_addr",  ins_addr, 32'h0);

        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_stall_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("wrap_stall_pc",    id_pc, 32'hFFFFFFFF);

`ifdef FETCH_PERF_COUNTERS_EN
        checkOutput("perf_fetches",   perf_fetches, 32'd10);
        checkOutput("perf_stalls",    perf_stalls, 32'd4);
        checkOutput("perf_redirects", perf_redirects, 32'd4);
`endif

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("async_rst_addr",  ins_addr, 32'h0);
        checkOutput("async_rst_pc",    id_pc, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("reboot_valid", {31'b0, id_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("reboot_valid2", {31'b0, id_valid}, 32'h1);
        checkOutput("reboot_instr",  id_instr, 32'h00300293);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that owns the program counter and drives the instruction memory's word address `ins_addr`.
- Captures the combinationally returned `instruction` into an IF/ID pipeline register that feeds decode through a valid/ready handshake.
- Handles:
  - decode back-pressure (stall),
  - branch/jump redirect with wrong-path squash,
  - halt on ECALL.

Parameters:
- XLEN, 32, width of PC, addresses and instructions.
- RESET_PC, 32'h0, word address fetched first after reset.
- PC_STEP, 1, PC increment per accepted fetch. Instruction memory is word-indexed, so the step is 1, not 4.
- HALT_INSN, 32'h00000073, encoding (ECALL) that stops fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ins_addr  output  XLEN  word address to instruction memory; equals the PC register.
- instruction  input  XLEN  instruction memory read data; combinational from `ins_addr`, same cycle.
- redirect_valid  input  1  execute stage requests a PC change (taken branch/jump).
- redirect_target  input  XLEN  new PC, a word address.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_ready  input  1  decode accepts the IF/ID contents this cycle.
- id_instr  output  XLEN  captured instruction.
- id_pc  output  XLEN  word address of `id_instr`.
- halted  output  1  fetch stopped on HALT_INSN.

Behaviour:
- Reset (async assert, any state): pc=RESET_PC, state=BOOT, id_valid=0, id_instr=0, id_pc=0, halted=0. Reset mid-operation discards the IF/ID contents immediately.
- States:
  - BOOT: one cycle with no capture, so `ins_addr` settles after async deassert. Always goes to RUN next edge.
  - RUN: normal fetch.
  - HALTED: pc frozen, no new capture.
- Load condition: load = (state==RUN) && (!id_valid || id_ready).
- Priority at each edge, highest first:
  1. redirect_valid: pc<=redirect_target; id_valid<=0 (squash wrong-path instruction, even if id_ready=1); state<=RUN, including from HALTED (the ECALL was wrong-path); halted<=0.
  2. load: id_instr<=instruction, id_pc<=pc, id_valid<=1.
     - If instruction==HALT_INSN: pc holds, state<=HALTED, halted<=1.
     - Otherwise: pc<=pc+PC_STEP.
  3. id_valid && id_ready && !load (HALTED or BOOT): id_valid<=0.
  4. Else hold all registers (stall: id_valid=1, id_ready=0 keeps id_instr/id_pc/pc stable).
- Latency: first valid instruction presented at the 2nd rising edge after rst_n deasserts. Steady state is 1 instruction/cycle with id_ready=1. A redirect costs exactly 1 bubble cycle: first target instruction valid at the edge after the redirect edge.
- PC arithmetic: unsigned modulo 2^XLEN; pc wraps from all-ones to 0 with no flag. Instruction memory uses the low address bits, so memory-depth wrap is the memory's concern.
- HALTED: ECALL stays in IF/ID until accepted, then id_valid=0. `ins_addr` keeps pointing at the ECALL address.
- redirect_valid in BOOT: pc updated, state still moves to RUN.
- All outputs registered except ins_addr, which is the pc register itself.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- When defined, adds three output ports, each XLEN wide, each reset to 0 and wrapping on overflow:
  - perf_fetches: increments on each load.
  - perf_stalls: increments each cycle state==RUN && id_valid && !id_ready.
  - perf_redirects: increments each redirect_valid edge.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release, id_ready=1, imem[0]=32'h00300293, imem[1]=32'h00400313 -> no capture at edge 1.
  - Edge 2: id_valid=1, id_instr=32'h00300293, id_pc=0, ins_addr=1.
  - Edge 3: id_instr=32'h00400313, id_pc=1.
- Stall: id_ready=0 for 3 cycles while id_pc=2 (id_instr=32'h005303b3) -> id_instr/id_pc/ins_addr stay 32'h005303b3/2/3 for all 3 cycles. id_ready=1 resumes with id_pc=3 next edge.
- Redirect: redirect_valid=1, redirect_target=8 while id_pc=4 and id_ready=1 -> next edge id_valid=0, ins_addr=8. The following edge id_pc=8, id_valid=1.
- Halt: imem[6]=32'h00000073 -> after capture, halted=1 and ins_addr stays 6. After decode accepts, id_valid=0 indefinitely. Then redirect_target=2 -> halted=0 and fetch resumes at 2.
- Wrap and reset: redirect_target=32'hFFFFFFFF -> id_pc=32'hFFFFFFFF, then ins_addr=0. Asserting rst_n=0 mid-stall clears id_valid asynchronously, without waiting for an edge.
- With FETCH_PERF_COUNTERS_EN: the sequence above yields counts matching loads, stall cycles and redirects exactly.
